// File: rtl/pipeline_pkg.sv
// Shared decode-stage widths for the MIPS32 pipeline.
package pipeline_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int IMM_W    = 16;
  localparam int NUM_REGS = 32;
endpackage

// File: rtl/reg_file_if.sv
// Decode-stage register file bus: read/write ports plus the immediate path.
interface reg_file_if
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int IMM_W  = pipeline_pkg::IMM_W
);
  logic [ADDR_W-1:0] read_addr_1;
  logic [ADDR_W-1:0] read_addr_2;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              write_enabled;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;
  logic [IMM_W-1:0]  imm_in;
  logic [DATA_W-1:0] imm_out;

  modport master (
    output read_addr_1, read_addr_2, write_addr, write_data, write_enabled, imm_in,
    input  data_1, data_2, imm_out
  );

  modport slave (
    input  read_addr_1, read_addr_2, write_addr, write_data, write_enabled, imm_in,
    output data_1, data_2, imm_out
  );
endinterface

// File: rtl/reg_file_sign_extend.sv
// Combinational immediate sign-extender: replicates the immediate's MSB up to DATA_W.
module sign_extend
  import pipeline_pkg::*;
#(
  parameter int IMM_W  = pipeline_pkg::IMM_W,
  parameter int DATA_W = pipeline_pkg::DATA_W
) (
  input  logic [IMM_W-1:0]  imm_in,
  output logic [DATA_W-1:0] imm_out
);
  assign imm_out = {{(DATA_W - IMM_W){imm_in[IMM_W-1]}}, imm_in};
endmodule

// File: rtl/reg_file.sv
// Decode-stage integer register file: two registered read ports with write-first
// bypass, one write port, hard-wired $0, and the immediate sign-extender.
module reg_file
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int IMM_W  = pipeline_pkg::IMM_W
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  localparam int REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [REGS];
  logic [DATA_W-1:0] rd_next_1;
  logic [DATA_W-1:0] rd_next_2;
  logic              wr_valid;

  assign wr_valid = bus.write_enabled && (bus.write_addr != '0);

  // Zero-detect first, then bypass: a discarded write to $0 never reaches the bypass.
  always_comb begin
    rd_next_1 = '0;
    rd_next_2 = '0;
    if (bus.read_addr_1 != '0) begin
      if (wr_valid && (bus.write_addr == bus.read_addr_1)) rd_next_1 = bus.write_data;
      else                                                 rd_next_1 = regs[bus.read_addr_1];
    end
    if (bus.read_addr_2 != '0) begin
      if (wr_valid && (bus.write_addr == bus.read_addr_2)) rd_next_2 = bus.write_data;
      else                                                 rd_next_2 = regs[bus.read_addr_2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs       <= '{default: '0};
      bus.data_1 <= '0;
      bus.data_2 <= '0;
    end else begin
      if (wr_valid) regs[bus.write_addr] <= bus.write_data;
      bus.data_1 <= rd_next_1;
      bus.data_2 <= rd_next_2;
    end
  end

  sign_extend #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_sign_extend (
    .imm_in  (bus.imm_in),
    .imm_out (bus.imm_out)
  );
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases followed by random traffic
// checked against an array-based model of the register file.
module tb_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] model [32];

  reg_file_if #(.DATA_W(32), .ADDR_W(5), .IMM_W(16)) bus ();

  reg_file #(.DATA_W(32), .ADDR_W(5), .IMM_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input string tag);
    logic [31:0] e1, e2;
    rst               = r;
    bus.write_enabled = we;
    bus.write_addr    = wa;
    bus.write_data    = wd;
    bus.read_addr_1   = a1;
    bus.read_addr_2   = a2;
    e1 = r ? 32'd0 : model_read(a1, we, wa, wd);
    e2 = r ? 32'd0 : model_read(a2, we, wa, wd);
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    check({tag, ".data_1"}, bus.data_1, e1);
    check({tag, ".data_2"}, bus.data_2, e2);
  endtask

  task automatic imm_check(input logic [15:0] imm, input string tag);
    int sx;
    bus.imm_in = imm;
    #1;
    sx = int'(shortint'(imm));
    check(tag, bus.imm_out, 32'(sx));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    bus.imm_in = '0;
    #2;

    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "reset");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31, "post_reset");

    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, "wr_r5");
    step(1'b0, 1'b1, 5'd6, 32'h12345678, 5'd0, 5'd0, "wr_r6");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, "rd_r5_r6");

    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr_r0_same_cycle");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd_r0");

    step(1'b0, 1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0, "wr_r7");
    step(1'b0, 1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7, "bypass_r7");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "rd_r7");

    step(1'b1, 1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3, "rst_vs_write");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5, "rd_after_rst");

    imm_check(16'h7FFF, "imm_7fff");
    imm_check(16'h8000, "imm_8000");
    imm_check(16'hFFFF, "imm_ffff");
    imm_check(16'h0000, "imm_0000");

    for (int n = 0; n < 400; n++) begin
      logic r, we;
      logic [4:0] wa, a1, a2;
      r  = ($urandom_range(0, 49) == 0);
      we = $urandom_range(0, 3) != 0;
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      step(r, we, wa, $urandom, a1, a2, "random");
      imm_check(16'($urandom), "imm_random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

Integer register file for the decode stage of the MIPS32 pipeline, with a companion immediate sign-extender. Provides two read ports addressed by the instruction's rs/rt fields, registered so the read data lines up with the other decode-stage outputs. Provides one write port driven by writeback. Register $0 is hard-wired to zero, and same-cycle writeback-to-decode hazards are resolved by an internal bypass.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2^ADDR_W = 32 registers)
- IMM_W, 16, width of the immediate fed to the sign-extender

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- read_addr_1  in  ADDR_W  index for read port 1 (rs)
- read_addr_2  in  ADDR_W  index for read port 2 (rt)
- write_addr  in  ADDR_W  index for the write port
- write_data  in  DATA_W  data to write
- write_enabled  in  1  write strobe, sampled at the clock edge
- data_1  out  DATA_W  registered read data, port 1
- data_2  out  DATA_W  registered read data, port 2
- imm_in  in  IMM_W  raw immediate
- imm_out  out  DATA_W  sign-extended immediate

## Operation
- Storage: 32 × DATA_W registers, indexed 0..31.
- Write: on a rising edge with write_enabled=1 and write_addr≠0, the register at write_addr takes the value of write_data.
- Writes to index 0 are discarded. Reading register 0 always returns 0.
- Read, port n:
  - On each rising edge, data_n is loaded with the contents of read_addr_n.
  - If read_addr_n=0, data_n is loaded with 0.
  - Otherwise, if write_enabled=1 and write_addr=read_addr_n in the same cycle, data_n is loaded with write_data. This is the write-first bypass.
- Both read ports are independent. Both may address the same register, and both may bypass in the same cycle.
- Sign extension: imm_out = {(DATA_W−IMM_W) copies of imm_in[IMM_W−1], imm_in}. It is purely combinational and does not depend on clk or rst.

## Timing
- Read latency is 1 cycle: addresses presented in cycle N appear on data_1/data_2 after edge N.
- Write is visible to a read issued in the same cycle through the bypass. Write latency to storage is 1 edge.
- Reset, on a rising edge with rst=1:
  - All 32 registers clear to 0.
  - data_1 and data_2 clear to 0.
  - rst takes priority over a simultaneous write, and that write is dropped.
- Reset mid-operation: the cycle after rst deasserts behaves as a fresh start. Reads return 0 until a register is written.
- imm_out has zero latency and is valid in the same cycle as imm_in.

## Structure
- Shared package pipeline_pkg holds DATA_W=32, ADDR_W=5, IMM_W=16 and NUM_REGS=32.
- Sub-module sign_extend: imm_in → imm_out, combinational, parameterised by IMM_W and DATA_W. It is instantiated inside reg_file.
- reg_file contains:
  - the storage array;
  - the write logic;
  - the two registered read ports, each with zero-detect and bypass mux.

## Test plan
- Reset: hold rst=1 for one edge, then read addresses 1 and 31 → data_1=0, data_2=0 after the next edge.
- Write/read: write 0xDEADBEEF to r5 and 0x12345678 to r6 on consecutive edges. Then read_addr_1=5, read_addr_2=6 → data_1=0xDEADBEEF and data_2=0x12345678 one edge later.
- Register $0:
  - write 0xFFFFFFFF to r0, then read r0 on both ports → both 0;
  - with write_enabled=1, write_addr=0 and read_addr_1=0 in the same cycle → data_1=0, not bypassed.
- Bypass: r7 holds 0x1. In one cycle, write 0xCAFEF00D to r7 with read_addr_1=read_addr_2=7 → both ports show 0xCAFEF00D after that edge.
- Reset priority: rst=1 and a write of 0xAAAA5555 to r3 on the same edge, then read r3 → 0.
- Sign extend:
  - imm_in=0x7FFF → imm_out=0x00007FFF;
  - 0x8000 → 0xFFFF8000;
  - 0xFFFF → 0xFFFFFFFF;
  - 0x0000 → 0x00000000.
